// File: rtl/ifm_feeder_32.sv
`default_nettype none
// ============================================================================
// Module   : ifm_feeder_32
// Brief    : Feeds one IFM vector per MAC window into a HEIGHT-row array,
//            optional per-row skew via macro IFM_FEEDER_SKEW_EN.
// Revision : 1.0
// ============================================================================
module ifm_feeder_32 #(
    parameter int HEIGHT  = 32,
    parameter int IWIDTH  = 16,
    parameter int MAC_CYC = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IWIDTH-1:0] in_ifm [HEIGHT],
    output logic signed [IWIDTH-1:0] ifm [HEIGHT],
    output logic [HEIGHT-1:0]        en_i,
    output logic [HEIGHT-1:0]        clr_i,
    output logic [HEIGHT-1:0]        mac_done,
    output logic                     busy
);
    localparam int               CNT_W  = $clog2(MAC_CYC + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAC_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_xfer;
    logic                      r_clr0;
    logic                      r_en0;
    logic                      w_done0;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [IWIDTH-1:0]  r_cap [HEIGHT];

    assign w_done0  = r_en0 && (r_cnt == C_LAST);
    assign in_ready = ((r_state == S_IDLE) && !rst) || ((r_state == S_RUN) && w_done0);
    assign w_xfer   = in_valid && in_ready;
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Without a follow-on vector, skip DRAIN when the last row is already done.
                if (w_done0 && !in_valid) begin
                    w_state_nxt = mac_done[HEIGHT-1] ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mac_done[HEIGHT-1]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr0 <= 1'b0;
            r_en0  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_clr0 <= w_xfer;
            if (w_xfer) begin
                r_en0 <= 1'b0;
                r_cnt <= '0;
            end else if (r_clr0) begin
                r_en0 <= 1'b1;
                r_cnt <= CNT_W'(1);
            end else if (w_done0) begin
                r_en0 <= 1'b0;
            end else if (r_en0) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < HEIGHT; h++) begin
                r_cap[h] <= '0;
            end
        end else if (w_xfer) begin
            for (int h = 0; h < HEIGHT; h++) begin
                r_cap[h] <= in_ifm[h];
            end
        end
    end

`ifdef IFM_FEEDER_SKEW_EN
    assign clr_i[0]    = r_clr0;
    assign en_i[0]     = r_en0;
    assign mac_done[0] = w_done0;
    assign ifm[0]      = r_cap[0];

    for (genvar h = 1; h < HEIGHT; h++) begin : g_skew
        logic                     r_clr_d;
        logic                     r_en_d;
        logic                     r_done_d;
        logic signed [IWIDTH-1:0] r_dat [h];

        // Controls ripple row to row; data needs its own h-deep line.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_clr_d  <= 1'b0;
                r_en_d   <= 1'b0;
                r_done_d <= 1'b0;
                for (int k = 0; k < h; k++) begin
                    r_dat[k] <= '0;
                end
            end else begin
                r_clr_d  <= clr_i[h-1];
                r_en_d   <= en_i[h-1];
                r_done_d <= mac_done[h-1];
                r_dat[0] <= r_cap[h];
                for (int k = 1; k < h; k++) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end

        assign clr_i[h]    = r_clr_d;
        assign en_i[h]     = r_en_d;
        assign mac_done[h] = r_done_d;
        assign ifm[h]      = r_dat[h-1];
    end
`else
    assign clr_i    = {HEIGHT{r_clr0}};
    assign en_i     = {HEIGHT{r_en0}};
    assign mac_done = {HEIGHT{w_done0}};

    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        assign ifm[h] = r_cap[h];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifm_feeder_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifm_feeder_32
// Brief    : Randomized self-checking bench for ifm_feeder_32 against a
//            transfer-history reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ifm_feeder_32;
    localparam int HEIGHT  = 32;
    localparam int IWIDTH  = 16;
    localparam int MAC_CYC = 4;
    localparam int FW      = HEIGHT * IWIDTH;
`ifdef IFM_FEEDER_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif
    localparam int SPAN = SKEW ? HEIGHT - 1 : 0;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     busy;
    logic signed [IWIDTH-1:0] in_ifm [HEIGHT];
    logic signed [IWIDTH-1:0] ifm [HEIGHT];
    logic [HEIGHT-1:0]        en_i;
    logic [HEIGHT-1:0]        clr_i;
    logic [HEIGHT-1:0]        mac_done;

    ifm_feeder_32 #(
        .HEIGHT  (HEIGHT),
        .IWIDTH  (IWIDTH),
        .MAC_CYC (MAC_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ifm   (in_ifm),
        .ifm      (ifm),
        .en_i     (en_i),
        .clr_i    (clr_i),
        .mac_done (mac_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a;
        logic [FW-1:0] d;
    } xfer_t;

    xfer_t q[$];
    int    t      = 0;
    int    errors = 0;
    int    checks = 0;
    bit    exp_rdy;

    function automatic logic [FW-1:0] flat(input logic signed [IWIDTH-1:0] v [HEIGHT]);
        logic [FW-1:0] r;
        r = '0;
        for (int h = 0; h < HEIGHT; h++) begin
            r[h*IWIDTH +: IWIDTH] = v[h];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Expected outputs derive from the list of accepted vectors and their acceptance cycles.
    task automatic check_cycle();
        logic [HEIGHT-1:0] eclr, een, edone;
        logic [FW-1:0]     edat;
        bit                ebusy, r0done;
        int                tp, best, a;
        if (rst) q.delete();
        while (q.size() > 1 && q[1].a + 1 + SPAN < t) void'(q.pop_front());
        eclr = '0; een = '0; edone = '0; edat = '0;
        ebusy = 1'b0; r0done = 1'b0;
        for (int h = 0; h < HEIGHT; h++) begin
            tp   = t - (SKEW ? h : 0);
            best = -1000;
            foreach (q[i]) begin
                a = q[i].a;
                if (tp == a + 1) eclr[h] = 1'b1;
                if (tp >= a + 2 && tp <= a + 1 + MAC_CYC) een[h] = 1'b1;
                if (tp == a + 1 + MAC_CYC) edone[h] = 1'b1;
                if (a + 1 <= tp && a > best) begin
                    best = a;
                    edat[h*IWIDTH +: IWIDTH] = q[i].d[h*IWIDTH +: IWIDTH];
                end
            end
        end
        foreach (q[i]) begin
            if (t >= q[i].a + 1 && t <= q[i].a + 1 + MAC_CYC + SPAN) ebusy = 1'b1;
            if (t == q[i].a + 1 + MAC_CYC) r0done = 1'b1;
        end
        exp_rdy = !rst && (!ebusy || r0done);
        chk("in_ready", FW'(in_ready), FW'(exp_rdy));
        chk("busy", FW'(busy), FW'(ebusy));
        chk("clr_i", FW'(clr_i), FW'(eclr));
        chk("en_i", FW'(en_i), FW'(een));
        chk("mac_done", FW'(mac_done), FW'(edone));
        chk("ifm", flat(ifm), edat);
    endtask

    task automatic tick();
        xfer_t x;
        #1;
        check_cycle();
        @(posedge clk);
        if (in_valid && exp_rdy) begin
            x.a = t;
            x.d = flat(in_ifm);
            q.push_back(x);
        end
        t++;
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int h = 0; h < HEIGHT; h++) in_ifm[h] = IWIDTH'($urandom);
    endtask

    initial begin
        for (int h = 0; h < HEIGHT; h++) in_ifm[h] = '0;
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // single vector, in_ifm[h] = h+1
        for (int h = 0; h < HEIGHT; h++) in_ifm[h] = IWIDTH'(h + 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rand_data();
        repeat (45) tick();

        // valid held high: back-to-back windows
        in_valid = 1'b1;
        repeat (22) begin
            rand_data();
            tick();
        end
        in_valid = 1'b0;
        repeat (45) tick();

        // extreme signed values
        rand_data();
        in_ifm[0]        = -16'sd32768;
        in_ifm[HEIGHT-1] = 16'sd32767;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (45) tick();

        // reset in the middle of a window
        rand_data();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();

        // random traffic with occasional resets
        repeat (600) begin
            in_valid = ($urandom_range(0, 2) != 0);
            rand_data();
            rst = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (45) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ifm_feeder_32.md
IFM_FEEDER_32 -- requirements
Module: ifm_feeder_32

Interface
REQ-001 SHALL have parameter HEIGHT, default 32, number of array rows fed.
REQ-002 SHALL have parameter IWIDTH, default 16, signed ifm element width.
REQ-003 SHALL have parameter MAC_CYC, default 256, en_i cycles per MAC window (legal range 2..65535).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, upstream vector valid.
REQ-008 SHALL have port in_ready, output, 1, feeder accepts vector this cycle.
REQ-009 SHALL have port in_ifm, input, HEIGHT x IWIDTH signed unpacked array, one element per row.
REQ-010 SHALL have port ifm, output, HEIGHT x IWIDTH signed unpacked array, per-row value to array.
REQ-011 SHALL have ports en_i, clr_i and mac_done, output, HEIGHT each, per-row array controls.
REQ-012 SHALL have port busy, output, 1, high while any row is mid-window.

Function
REQ-013 SHALL implement FSM IDLE, RUN, DRAIN; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-014 SHALL assert in_ready in IDLE, and in RUN only on the row-0 mac_done cycle; in_ready SHALL be 0 in DRAIN.
REQ-015 For a transfer at edge A, row 0 SHALL drive clr_i[0]=1 and en_i[0]=0 in cycle A+1.
REQ-016 Row 0 SHALL drive en_i[0]=1 in cycles A+2..A+1+MAC_CYC, with mac_done[0]=1 only in cycle A+1+MAC_CYC.
REQ-017 ifm[0] SHALL equal in_ifm[0] captured at A, from cycle A+1 until the next clr_i[0].
REQ-018 Row h (with skew) SHALL reproduce row-0 clr_i/en_i/mac_done timing delayed by h cycles, using its own element in_ifm[h] captured at A.
REQ-019 A transfer on the row-0 mac_done cycle SHALL start the next window with clr_i[0] in the next cycle (no bubble); FSM stays RUN.
REQ-020 No transfer on the row-0 mac_done cycle SHALL move RUN to DRAIN.
REQ-021 DRAIN SHALL last until row HEIGHT-1 has emitted mac_done, then go to IDLE in the next cycle.
REQ-022 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE.
REQ-023 Window counter SHALL be clog2(MAC_CYC+1) bits, cleared on each clr_i[0], and SHALL never wrap mid-window.
REQ-024 ifm values SHALL pass bit-exact, with no sign or width change (e.g. -32768 preserved).

Reset
REQ-025 rst SHALL immediately force FSM to IDLE, counter to 0, all skew stages to 0, and all outputs to 0 (in_ready=0, busy=0, ifm=0).
REQ-026 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-027 Reset mid-RUN or mid-DRAIN SHALL abort all windows; no mac_done SHALL appear for an aborted vector.

Configuration
REQ-028 Macro IFM_FEEDER_SKEW_EN defined: per-row h-cycle skew (REQ-018) and DRAIN of HEIGHT-1 cycles apply.
REQ-029 Macro IFM_FEEDER_SKEW_EN undefined: all rows SHALL equal row-0 timing, and DRAIN SHALL go to IDLE the cycle after the last row-0 mac_done.

Verification (HEIGHT=32, MAC_CYC=4, skew on unless stated)
REQ-030 Single transfer at A, in_ifm[h]=h+1 -> clr_i[0]@A+1, en_i[0]@A+2..A+5, mac_done[0]@A+5; clr_i[31]@A+32, mac_done[31]@A+36; ifm[5]=6; busy=0 from A+37.
REQ-031 Back-to-back: second transfer at A+5 -> clr_i[0]@A+6, mac_done[0]@A+10, and no idle cycle on row 0.
REQ-032 in_valid=1 held from A+1 -> in_ready=0 in A+1..A+4, second transfer occurs at A+5.
REQ-033 rst pulse at A+3 -> en_i, mac_done and ifm all 0 immediately; no mac_done[0] at A+5; in_ready=1 after release.
REQ-034 Skew macro off, single transfer at A -> mac_done[31]@A+5, busy=0 from A+6.
REQ-035 in_ifm[0]=-32768 and in_ifm[31]=32767 -> ifm[0]=-32768 from A+1 and ifm[31]=32767 from A+32, unchanged.
